// File: rtl/emd_pkg.sv
// Shared types for the EMD extrema detector.
//   state_t : frame FSM states (IDLE, RUN, FLUSH)
//   dir_t   : last non-flat slope direction seen in the frame
//   KIND_*  : encoding of the registered result kind
package emd_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_MAX  = 2'd1;
    localparam logic [1:0] KIND_MIN  = 2'd2;
    localparam logic [1:0] KIND_END  = 2'd3;

endpackage

// File: rtl/emd_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count one event; holds at all-ones
//   q          : current count
module emd_sat_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                q <= '0;
        else if (clr)              q <= '0;
        else if (inc && (q != '1)) q <= q + CW'(1);
    end

endmodule

// File: rtl/emd_extrema_det.sv
// Streaming local-extremum detector for the EMD sifting path.
// Tracks the slope direction across a frame and reports each local max/min
// (index, value, kind) one cycle after the beat that resolves it. Optionally
// collapses flat runs into one extremum and reports the frame endpoints.
//   clk, rst_n        : clock, async active-low reset
//   clr               : sync frame restart, dominates in_vld
//   in_vld/in_rdy     : sample handshake; in_dat signed sample, in_last ends frame
//   out_vld           : one-cycle result strobe with out_idx/out_dat
//   out_max/min/end   : result kind
//   max_cnt/min_cnt   : saturating per-frame extrema counts
module emd_extrema_det
    import emd_pkg::*;
#(
    parameter int DW         = 16,
    parameter int TW         = 16,
    parameter int CW         = 16,
    parameter bit PLATEAU_EN = 1'b1,
    parameter bit END_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic signed [DW-1:0] in_dat,
    input  logic                 in_last,
    output logic                 out_vld,
    output logic [TW-1:0]        out_idx,
    output logic signed [DW-1:0] out_dat,
    output logic                 out_max,
    output logic                 out_min,
    output logic                 out_end,
    output logic [CW-1:0]        max_cnt,
    output logic [CW-1:0]        min_cnt
);

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [TW-1:0] idx_q, idx_d, cidx_q, cidx_d, oidx_q, oidx_d;
    logic [DW-1:0] cdat_q, cdat_d, prev_q, prev_d, odat_q, odat_d;
    logic [1:0]    kind_q, kind_d;
    logic          vld_q, vld_d, rdy_q, rdy_d;
    logic          inc_max, inc_min, cnt_clr;
    logic          beat, d_pos, d_neg;
    logic [DW:0]   diff;

    assign beat  = in_vld & rdy_q;
    // Sign-extended difference cannot overflow, so the extremes compare correctly.
    assign diff  = {in_dat[DW-1], in_dat} - {prev_q[DW-1], prev_q};
    assign d_neg = diff[DW];
    assign d_pos = !diff[DW] && (diff != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= NONE;
            idx_q   <= '0;
            cidx_q  <= '0;
            cdat_q  <= '0;
            prev_q  <= '0;
            oidx_q  <= '0;
            odat_q  <= '0;
            kind_q  <= KIND_NONE;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            cidx_q  <= cidx_d;
            cdat_q  <= cdat_d;
            prev_q  <= prev_d;
            oidx_q  <= oidx_d;
            odat_q  <= odat_d;
            kind_q  <= kind_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        cidx_d  = cidx_q;
        cdat_d  = cdat_q;
        prev_d  = prev_q;
        vld_d   = 1'b0;
        kind_d  = KIND_NONE;
        oidx_d  = '0;
        odat_d  = '0;
        inc_max = 1'b0;
        inc_min = 1'b0;
        cnt_clr = 1'b0;
        if (clr) begin
            state_d = IDLE;
            dir_d   = NONE;
            idx_d   = '0;
            cidx_d  = '0;
            cdat_d  = '0;
            prev_d  = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (beat) begin
                    cnt_clr = 1'b1;
                    prev_d  = in_dat;
                    dir_d   = NONE;
                    if (END_EN) begin
                        vld_d  = 1'b1;
                        kind_d = KIND_END;
                        odat_d = in_dat;
                    end
                    // A one-sample frame ends here with no FLUSH.
                    idx_d   = in_last ? '0 : TW'(1);
                    state_d = in_last ? IDLE : RUN;
                end
                RUN: if (beat) begin
                    prev_d = in_dat;
                    idx_d  = idx_q + TW'(1);
                    if (d_pos) begin
                        if (dir_q == DOWN) begin
                            vld_d   = 1'b1;
                            kind_d  = KIND_MIN;
                            oidx_d  = cidx_q;
                            odat_d  = cdat_q;
                            inc_min = 1'b1;
                        end
                        dir_d  = UP;
                        cidx_d = idx_q;
                        cdat_d = in_dat;
                    end else if (d_neg) begin
                        if (dir_q == UP) begin
                            vld_d   = 1'b1;
                            kind_d  = KIND_MAX;
                            oidx_d  = cidx_q;
                            odat_d  = cdat_q;
                            inc_max = 1'b1;
                        end
                        dir_d  = DOWN;
                        cidx_d = idx_q;
                        cdat_d = in_dat;
                    end else if (!PLATEAU_EN) begin
                        dir_d = NONE;
                    end
                    if (in_last) begin
                        if (END_EN) begin
                            // Candidate is no longer needed; park the last sample there for FLUSH.
                            state_d = FLUSH;
                            cidx_d  = idx_q;
                            cdat_d  = in_dat;
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                            dir_d   = NONE;
                            cidx_d  = '0;
                            cdat_d  = '0;
                        end
                    end
                end
                FLUSH: begin
                    vld_d   = 1'b1;
                    kind_d  = KIND_END;
                    oidx_d  = cidx_q;
                    odat_d  = cdat_q;
                    state_d = IDLE;
                    idx_d   = '0;
                    dir_d   = NONE;
                    cidx_d  = '0;
                    cdat_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        rdy_d = (state_d != FLUSH);
    end

    emd_sat_cnt #(.CW(CW)) u_max_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(inc_max), .q(max_cnt)
    );
    emd_sat_cnt #(.CW(CW)) u_min_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(inc_min), .q(min_cnt)
    );

    assign in_rdy  = rdy_q;
    assign out_vld = vld_q;
    assign out_idx = oidx_q;
    assign out_dat = odat_q;
    assign out_max = (kind_q == KIND_MAX);
    assign out_min = (kind_q == KIND_MIN);
    assign out_end = (kind_q == KIND_END);

endmodule

// File: tb/tb_emd_extrema_det.sv
// Directed bench: dut a (defaults), dut p (strict, no plateau), dut w (TW=3, CW=2).
// All three share the input stream; each step checks the instance it targets.
module tb_emd_extrema_det;

    logic               clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_vld = 1'b0, in_last = 1'b0;
    logic signed [15:0] in_dat = '0;

    logic        a_rdy, a_vld, a_max, a_min, a_end;
    logic [15:0] a_idx, a_dat, a_mxc, a_mnc;
    logic        p_rdy, p_vld, p_max, p_min, p_end;
    logic [15:0] p_idx, p_dat, p_mxc, p_mnc;
    logic        w_rdy, w_vld, w_max, w_min, w_end;
    logic [2:0]  w_idx;
    logic [15:0] w_dat;
    logic [1:0]  w_mxc, w_mnc;

    logic [35:0] obs_a, obs_w;
    assign obs_a = {a_vld, a_max, a_min, a_end, a_idx, a_dat};
    assign obs_w = {w_vld, w_max, w_min, w_end, 13'd0, w_idx, w_dat};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    emd_extrema_det u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(a_rdy),
        .in_dat(in_dat), .in_last(in_last), .out_vld(a_vld), .out_idx(a_idx),
        .out_dat(a_dat), .out_max(a_max), .out_min(a_min), .out_end(a_end),
        .max_cnt(a_mxc), .min_cnt(a_mnc)
    );
    emd_extrema_det #(.PLATEAU_EN(1'b0)) u_p (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(p_rdy),
        .in_dat(in_dat), .in_last(in_last), .out_vld(p_vld), .out_idx(p_idx),
        .out_dat(p_dat), .out_max(p_max), .out_min(p_min), .out_end(p_end),
        .max_cnt(p_mxc), .min_cnt(p_mnc)
    );
    emd_extrema_det #(.TW(3), .CW(2)) u_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(w_rdy),
        .in_dat(in_dat), .in_last(in_last), .out_vld(w_vld), .out_idx(w_idx),
        .out_dat(w_dat), .out_max(w_max), .out_min(w_min), .out_end(w_end),
        .max_cnt(w_mxc), .min_cnt(w_mnc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] res(input logic mx, input logic mn, input logic en,
                                        input logic [15:0] idx, input logic [15:0] dat);
        return {28'd0, 1'b1, mx, mn, en, idx, dat};
    endfunction

    task automatic beat(input logic [15:0] d, input logic l);
        in_vld  = 1'b1;
        in_dat  = d;
        in_last = l;
        @(posedge clk); #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle();
        in_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [15:0] zz_idx [10] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    logic [1:0]  zz_kind[10] = '{3, 0, 1, 2, 1, 2, 1, 2, 1, 2};  // 0 none,1 max,2 min,3 end

    initial begin
        // reset state
        #12;
        chk("rst_out", obs_a, 0);
        chk("rst_rdy", a_rdy, 0);
        chk("rst_cnt", {a_mxc, a_mnc}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", a_rdy, 1);

        // 1: frame 1,3,2
        beat(16'd1, 0); chk("t1_end0", obs_a, res(0, 0, 1, 0, 1));
        beat(16'd3, 0); chk("t1_b1", a_vld, 0);
        beat(16'd2, 1); chk("t1_max", obs_a, res(1, 0, 0, 1, 3));
        chk("t1_rdy_flush", a_rdy, 0);
        idle();         chk("t1_end2", obs_a, res(0, 0, 1, 2, 2));
        chk("t1_maxcnt", a_mxc, 1);
        chk("t1_rdy_idle", a_rdy, 1);

        // 2: plateau frame 0,5,5,5,1,1,4
        beat(16'd0, 0); chk("t2_end0", obs_a, res(0, 0, 1, 0, 0));
        beat(16'd5, 0);
        beat(16'd5, 0);
        beat(16'd5, 0); chk("t2_b3", a_vld, 0);
        beat(16'd1, 0); chk("t2_max", obs_a, res(1, 0, 0, 1, 5));
        chk("t2_p_nomax", p_vld, 0);
        beat(16'd1, 0); chk("t2_b5", a_vld, 0);
        beat(16'd4, 1); chk("t2_min", obs_a, res(0, 1, 0, 4, 1));
        chk("t2_p_nomin", p_vld, 0);
        idle();         chk("t2_end6", obs_a, res(0, 0, 1, 6, 4));
        chk("t2_p_end6", {p_vld, p_end, p_idx, p_dat}, {2'b11, 16'd6, 16'd4});
        chk("t2_cnt", {a_mxc, a_mnc}, {16'd1, 16'd1});
        chk("t2_p_cnt", {p_mxc, p_mnc}, 0);

        // 3: signed extremes
        beat(16'h8000, 0); chk("t3_end0", obs_a, res(0, 0, 1, 0, 16'h8000));
        beat(16'h7fff, 0); chk("t3_b1", a_vld, 0);
        beat(16'h8000, 1); chk("t3_max", obs_a, res(1, 0, 0, 1, 16'h7fff));
        idle();            chk("t3_end2", obs_a, res(0, 0, 1, 2, 16'h8000));

        // 4: single-sample frame
        beat(16'd7, 1); chk("t4_end", obs_a, res(0, 0, 1, 0, 7));
        chk("t4_rdy", a_rdy, 1);
        chk("t4_cnt", {a_mxc, a_mnc}, 0);
        idle();         chk("t4_once", a_vld, 0);
        chk("t4_rdy2", a_rdy, 1);

        // 5a: CLR during FLUSH drops the END result
        beat(16'd1, 0);
        beat(16'd3, 0);
        beat(16'd2, 1); chk("t5_max", obs_a, res(1, 0, 0, 1, 3));
        clr = 1'b1;
        idle();         chk("t5_noend", a_vld, 0);
        chk("t5_cnt", {a_mxc, a_mnc}, 0);
        chk("t5_rdy", a_rdy, 1);
        clr = 1'b0;
        idle();         chk("t5_quiet", a_vld, 0);

        // 5b: asynchronous reset mid-frame
        beat(16'd1, 0);
        beat(16'd3, 0);
        beat(16'd2, 0); chk("t5_pre_rst", obs_a, res(1, 0, 0, 1, 3));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out", obs_a, 0);
        chk("t5_rst_rdy_cnt", {a_rdy, a_mxc, a_mnc}, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        beat(16'd6, 0); chk("t5_fresh", obs_a, res(0, 0, 1, 0, 6));
        beat(16'd6, 1); chk("t5_flat", a_vld, 0);
        idle();         chk("t5_fresh_end", obs_a, res(0, 0, 1, 1, 6));

        // 6: zig-zag with TW=3 index wrap and CW=2 saturation
        for (int n = 0; n < 10; n++) begin
            beat(16'(n % 2), (n == 9));
            if (zz_kind[n] == 2'd0)
                chk($sformatf("t6_b%0d", n), w_vld, 0);
            else
                chk($sformatf("t6_b%0d", n), obs_w,
                    res(zz_kind[n] == 2'd1, zz_kind[n] == 2'd2, zz_kind[n] == 2'd3,
                        zz_idx[n], 16'((n == 0) ? 0 : ((n - 1) % 2))));
            if (n == 4) chk("t6_mxc4", w_mxc, 2);
        end
        idle();         chk("t6_end", obs_w, res(0, 0, 1, 1, 1));
        chk("t6_sat", {w_mxc, w_mnc}, {2'd3, 2'd3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
